// File: rtl/add_arbiter.sv
// add_arbiter
//   Two-requester front end for one shared combinational adder. A requester
//   hands over operands with a valid/ready handshake. The arbiter registers
//   them, drives the external adder for one cycle, and captures the result.
//   It then presents the result to the requester that owns the operation
//   until that requester consumes it. Only one operation is in flight at a
//   time. Ties are broken round-robin.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshake
//   req{0,1}_a/_b/_cin       operands and carry-in
//   rsp{0,1}_valid/_ready    response handshake
//   rsp{0,1}_sum/_cout/_of   result fields (meaningful for the owner only)
//   add_a/_b/_cin            registered operands toward the shared adder
//   add_sum/_cout/_of        shared adder results
//   busy                     high whenever the FSM is not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready goes to the granted requester
// EXEC  | operands sit on the adder; its outputs are captured this cycle
// RESP  | result is held for the owner until its rsp_ready
module add_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp0_of,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             rsp1_of,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_of,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, next_state;

  logic             prio;   // tie winner: 0 = req0, 1 = req1
  logic             owner;  // requester of the operation in flight
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_of;

  logic grant0, grant1, accept, consume;

  // Grants include the valids, so a grant is already a handshake. The rst
  // term keeps ready low while reset is held even though IDLE is active.
  assign grant0 = !rst && req0_valid && (!req1_valid || !prio);
  assign grant1 = !rst && req1_valid && (!req0_valid ||  prio);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 || grant1;
        if (accept) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid =  owner;
        // rsp_ready from the non-owner is deliberately not looked at
        consume    = owner ? rsp1_ready : rsp0_ready;
        if (consume) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_of   <= 1'b0;
    end else begin
      if (accept) begin
        owner  <= grant1;
        op_a   <= grant1 ? req1_a   : req0_a;
        op_b   <= grant1 ? req1_b   : req0_b;
        op_cin <= grant1 ? req1_cin : req0_cin;
      end
      if (state == EXEC) begin
        res_sum  <= add_sum;
        res_cout <= add_cout;
        res_of   <= add_of;
      end
      if (consume) prio <= !owner;
    end
  end

  // The adder sees only registers, so no request-side glitches reach it.
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;

  assign rsp0_sum  = res_sum;
  assign rsp0_cout = res_cout;
  assign rsp0_of   = res_of;
  assign rsp1_sum  = res_sum;
  assign rsp1_cout = res_cout;
  assign rsp1_of   = res_of;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
module tb_add_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp0_cout, rsp0_of;
  logic         rsp1_valid, rsp1_ready, rsp1_cout, rsp1_of;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout, add_of;
  logic         busy;

  always #5 clk = ~clk;

  add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout), .rsp0_of(rsp0_of),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout), .rsp1_of(rsp1_of),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_of(add_of),
    .busy(busy)
  );

  // external shared adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_of = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  typedef struct {
    logic         owner;
    logic [W-1:0] sum;
    logic         cout;
    logic         of;
    int           hs;
  } exp_t;

  exp_t         sb[$];
  logic         log_owner[$];
  logic [W-1:0] log_sum[$];
  logic         log_cout[$];
  logic         log_of[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_done = 0;
  bit           acc0, acc1;

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t     e;
    logic [W:0] s;
    s       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.owner = o;
    e.sum   = s[W-1:0];
    e.cout  = s[W];
    e.of    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    e.hs    = cyc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    logic         v, r, co, o;
    logic [W-1:0] s;
    @(negedge clk);
    acc0 = 0;
    acc1 = 0;
    chk("ready_onehot", req0_ready & req1_ready, 0);
    chk("rsp_valid_onehot", rsp0_valid & rsp1_valid, 0);
    if (!rst && (req0_valid || req1_valid))
      chk("busy_vs_ready", busy, !(req0_ready || req1_ready));
    for (int i = 0; i < 2; i++) begin
      v  = (i == 0) ? rsp0_valid : rsp1_valid;
      r  = (i == 0) ? rsp0_ready : rsp1_ready;
      s  = (i == 0) ? rsp0_sum   : rsp1_sum;
      co = (i == 0) ? rsp0_cout  : rsp1_cout;
      o  = (i == 0) ? rsp0_of    : rsp1_of;
      if (v) begin
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("rsp_owner", i, sb[0].owner);
          if (!lat_done) begin
            chk("latency", cyc - sb[0].hs, 2);
            lat_done = 1;
          end
          if (r) begin
            chk("rsp_sum", s, sb[0].sum);
            chk("rsp_cout", co, sb[0].cout);
            chk("rsp_of", o, sb[0].of);
            log_owner.push_back(i[0]);
            log_sum.push_back(s);
            log_cout.push_back(co);
            log_of.push_back(o);
            void'(sb.pop_front());
            lat_done = 0;
          end
        end
      end
    end
    if (req0_valid && req0_ready) begin
      sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
      acc0 = 1;
    end
    if (req1_valid && req1_ready) begin
      sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
      acc1 = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic clear_log();
    log_owner.delete();
    log_sum.delete();
    log_cout.delete();
    log_of.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_cin = 1'b1;
    req1_valid = 1'b0; req1_a = 32'h0; req1_b = 32'h0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    step();
    // reset state
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_rsp0_sum", rsp0_sum, 0);

    // single request 5 + 3 + 1
    rst = 1'b0;
    clear_log();
    #1;
    chk("t1_ready0", req0_ready, 1);
    step();
    chk("t1_accept", acc0, 1);
    req0_valid = 1'b0;
    chk("t1_add_a", add_a, 32'h5);
    chk("t1_add_b", add_b, 32'h3);
    chk("t1_add_cin", add_cin, 1);
    chk("t1_busy", busy, 1);
    drain(10);
    chk("t1_nrsp", log_owner.size(), 1);
    chk("t1_sum", log_sum[0], 32'h9);
    chk("t1_cout", log_cout[0], 0);
    chk("t1_of", log_of[0], 0);

    // tie from reset
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h1; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_cin = 1'b0;
    step();
    rst = 1'b0;
    clear_log();
    #1;
    chk("t2_tie_ready0", req0_ready, 1);
    chk("t2_tie_ready1", req1_ready, 0);
    step();
    chk("t2_accept0", acc0, 1);
    req0_valid = 1'b0;
    n = 0;
    while (!acc1 && n < 20) begin step(); n++; end
    chk("t2_req1_accept", acc1, 1);
    req1_valid = 1'b0;
    drain(10);
    chk("t2_nrsp", log_owner.size(), 2);
    chk("t2_owner0", log_owner[0], 0);
    chk("t2_sum0", log_sum[0], 32'h8000_0000);
    chk("t2_cout0", log_cout[0], 0);
    chk("t2_of0", log_of[0], 1);
    chk("t2_owner1", log_owner[1], 1);
    chk("t2_sum1", log_sum[1], 32'h0);
    chk("t2_cout1", log_cout[1], 1);
    chk("t2_of1", log_of[1], 0);

    // retie after req1 served: req0 wins; then backpressure on rsp1
    req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd20;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200; req1_cin = 1'b1;
    rsp1_ready = 1'b0;
    #1;
    chk("t3_retie_ready0", req0_ready, 1);
    chk("t3_retie_ready1", req1_ready, 0);
    step();
    chk("t3_accept0", acc0, 1);
    req0_valid = 1'b0;
    n = 0;
    while (!acc1 && n < 20) begin step(); n++; end
    chk("t3_req1_accept", acc1, 1);
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_cin = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!rsp1_valid && n < 10) begin step(); n++; end
    chk("t3_rsp1_seen", rsp1_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", rsp1_valid, 1);
      chk("t3_hold_sum", rsp1_sum, 32'h12D);
      chk("t3_hold_ready0", req0_ready, 0);
      chk("t3_hold_busy", busy, 1);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    req1_valid = 1'b1;
    #1;
    chk("t3_idle_busy", busy, 0);
    chk("t3_rr_ready0", req0_ready, 1);
    chk("t3_rr_ready1", req1_ready, 0);

    // reset one cycle after accept
    step();
    chk("t4_accept0", acc0, 1);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_rsp0_valid", rsp0_valid, 0);
    chk("t4_req1_ready", req1_ready, 0);
    chk("t4_add_a", add_a, 0);
    chk("t4_add_b", add_b, 0);
    sb.delete();
    lat_done = 0;
    clear_log();
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    repeat (6) step();
    chk("t4_no_rsp", log_owner.size(), 0);
    chk("t4_idle", busy, 0);

    // continuous traffic from both sides
    clear_log();
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
    n = 0;
    while (log_owner.size() < 10 && n < 200) begin
      step();
      n++;
      if (acc0) begin req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1)); end
      if (acc1) begin req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1)); end
    end
    chk("t5_nrsp", log_owner.size(), 10);
    for (int i = 0; i < log_owner.size(); i++)
      chk("t5_alternation", log_owner[i], i % 2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
